mem_ctrl: RTL
=============

// Module: mem_ctrl
// PURPOSE
//  Load/store front end for the byte-wide ram. It takes one 1/2/4/8-byte
//  access per handshake from the core's MEM stage and serialises it into
//  per-byte ram cycles. Read bytes are assembled big-endian and sign- or
//  zero-extended to 64 bits. Misaligned accesses are rejected with resp_err.
// PARAMETERS
//  MADDR_SZ  32  width of byte addresses (req_addr, mem_raddr, mem_waddr)
//  DATA_W    64  core data width; fixed at 64, not otherwise supported
// PORTS
//  clk          in   1         sole clock; rising edge
//  rst          in   1         asynchronous, active-low reset
//  req_valid    in   1         access request present
//  req_ready    out  1         1 = request accepted at this edge
//  req_we       in   1         1 = store, 0 = load
//  req_size     in   2         0 = byte, 1 = half, 2 = word, 3 = dword (N = 1<<size)
//  req_signed   in   1         load only: 1 = sign-extend, 0 = zero-extend
//  req_addr     in   MADDR_SZ  byte address of the MSB (lowest address)
//  req_wdata    in   64        store data; low N bytes are used
//  resp_valid   out  1         one-cycle completion pulse
//  resp_err     out  1         qualifies resp_valid: 1 = misaligned, nothing done
//  resp_rdata   out  64        load result; valid with resp_valid
//  mem_raddr    out  MADDR_SZ  ram read address
//  mem_dataout  in   8         ram combinational read data
//  mem_re       out  1         high during read byte cycles
//  mem_waddr    out  MADDR_SZ  ram write address
//  mem_datain   out  8         ram write byte
//  mem_we       out  1         ram writes on its rising edge
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; every output and internal register = 0,
//   except req_ready, which is 1 in IDLE.
//  States and transitions:
//   IDLE -> RD / WSETUP / DONE.
//   req_ready = (state==IDLE). Accept = req_valid & req_ready at edge E0.
//   All request fields are latched at E0. The byte index i starts at 0.
//  Alignment: req_addr % N != 0 -> go to DONE with resp_err=1, resp_rdata=0.
//   No mem_re or mem_we activity occurs.
//  RD: mem_raddr = base+i and mem_re = 1.
//   Each edge shifts mem_dataout into the low byte of the accumulator.
//   After byte N-1, go to DONE. Load resp_valid is high in the cycle after
//   edge E0+N.
//  WSETUP: mem_waddr = base+i, mem_datain = byte (N-1-i) of req_wdata,
//   mem_we = 0. Next state is WSTROBE.
//  WSTROBE: same address and data, mem_we = 1. Address and data are stable
//   for the whole strobe. Go to WSETUP with i+1, or to DONE after byte N-1.
//   Store resp_valid is high in the cycle after edge E0+2N.
//  DONE: resp_valid = 1 for exactly one cycle, then IDLE.
//   There is no response backpressure. req_ready is 0 in DONE, so the
//   minimum gap between accepts is N+2 cycles for loads and 2N+2 for stores.
//  Byte order is big-endian: base+0 carries the most significant byte.
//  Extension: the N-byte value is sign-extended from bit 8N-1 if req_signed,
//   else zero-extended. req_signed is ignored for N = 8 and for stores.
//  Address arithmetic is MADDR_SZ-bit modulo. An aligned access never wraps.
//  resp_rdata holds its value until the next response. Stores leave it
//   unchanged.
//  Reset mid-operation:
//   mem_we falls immediately. The falling edge causes no write.
//   Bytes already strobed stay written. No resp_valid is issued.
//   The controller is in IDLE on release.
//  req_valid while busy is ignored until req_ready. The requester must hold it.
// TESTING
//  1. Store dword 0x0123456789ABCDEF @0x100:
//     -> 8 mem_we rising edges, waddr 0x100..0x107, data 01,23,..,EF;
//     -> resp_valid after E0+16, resp_err=0.
//  2. Load dword @0x100 after test 1:
//     -> mem_raddr 0x100..0x107;
//     -> resp_rdata=0x0123456789ABCDEF, resp_valid after E0+8.
//  3. Loads after test 1:
//     -> byte @0x107 signed -> 0xFFFFFFFFFFFFFFEF; unsigned -> 0x00000000000000EF;
//     -> half @0x104 signed -> 0xFFFFFFFFFFFF89AB.
//  4. Load word @0x102:
//     -> resp_valid+resp_err in the cycle after E0, resp_rdata=0;
//     -> mem_re never high, no mem_we edge.
//  5. Store word 0xAABBCCDD @0x200; drop rst after the 2nd strobe:
//     -> mem_we=0 at once; ram[0x200..0x201]=AA,BB; 0x202..0x203 unchanged;
//     -> req_ready=1 after release.
//  6. Hold req_valid through a dword store:
//     -> req_ready=0 until DONE passes;
//     -> the 2nd request is accepted exactly 1 cycle after resp_valid.

Source files
------------

// File: rtl/mem_ctrl.sv
// ============================================================================
// Module   : mem_ctrl
// Function : Turns one 1/2/4/8-byte load or store per handshake into byte-wide
//            ram cycles. Data is big-endian and loads are sign/zero-extended.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_ctrl #(
  parameter int MADDR_SZ = 32,
  parameter int DATA_W   = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [1:0]          req_size,
  input  logic                req_signed,
  input  logic [MADDR_SZ-1:0] req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                resp_valid,
  output logic                resp_err,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic [MADDR_SZ-1:0] mem_raddr,
  input  logic [7:0]          mem_dataout,
  output logic                mem_re,
  output logic [MADDR_SZ-1:0] mem_waddr,
  output logic [7:0]          mem_datain,
  output logic                mem_we
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD      = 3'd1,
    S_WSETUP  = 3'd2,
    S_WSTROBE = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t              r_state;
  logic [1:0]          r_size;
  logic                r_signed;
  logic [2:0]          r_nm1;
  logic [2:0]          r_idx;
  logic [DATA_W-1:0]   r_acc;
  logic [DATA_W-1:0]   r_wsh;

  logic [2:0]          w_nm1;
  logic                w_misaligned;
  logic [DATA_W-1:0]   w_wsh;
  logic [DATA_W-1:0]   w_acc_next;

  always_comb begin
    w_nm1 = 3'd0;
    case (req_size)
      2'd0:    w_nm1 = 3'd0;
      2'd1:    w_nm1 = 3'd1;
      2'd2:    w_nm1 = 3'd3;
      default: w_nm1 = 3'd7;
    endcase
  end

  assign w_misaligned = |(req_addr[2:0] & w_nm1);
  // Left-justify the N store bytes so the next byte to send is always the top one.
  assign w_wsh        = req_wdata << {3'd7 - w_nm1, 3'b000};
  assign w_acc_next   = {r_acc[DATA_W-9:0], mem_dataout};

  function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] v,
                                                input logic [1:0] size,
                                                input logic sgn);
    logic [DATA_W-1:0] r;
    r = v;
    case (size)
      2'd0:    r = {{(DATA_W-8){sgn & v[7]}},   v[7:0]};
      2'd1:    r = {{(DATA_W-16){sgn & v[15]}}, v[15:0]};
      2'd2:    r = {{(DATA_W-32){sgn & v[31]}}, v[31:0]};
      default: r = v;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_size     <= 2'd0;
      r_signed   <= 1'b0;
      r_nm1      <= 3'd0;
      r_idx      <= 3'd0;
      r_acc      <= '0;
      r_wsh      <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      mem_raddr  <= '0;
      mem_re     <= 1'b0;
      mem_waddr  <= '0;
      mem_datain <= 8'd0;
      mem_we     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            r_size    <= req_size;
            r_signed  <= req_signed;
            r_nm1     <= w_nm1;
            r_idx     <= 3'd0;
            r_acc     <= '0;
            if (w_misaligned) begin
              r_state    <= S_DONE;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else if (req_we) begin
              r_state    <= S_WSETUP;
              mem_waddr  <= req_addr;
              mem_datain <= w_wsh[DATA_W-1 -: 8];
              r_wsh      <= w_wsh << 8;
            end else begin
              r_state   <= S_RD;
              mem_raddr <= req_addr;
              mem_re    <= 1'b1;
            end
          end
        end
        S_RD: begin
          r_acc <= w_acc_next;
          r_idx <= r_idx + 3'd1;
          if (r_idx == r_nm1) begin
            mem_re     <= 1'b0;
            r_state    <= S_DONE;
            resp_valid <= 1'b1;
            resp_rdata <= extend(w_acc_next, r_size, r_signed);
          end else begin
            mem_raddr <= mem_raddr + MADDR_SZ'(1);
          end
        end
        S_WSETUP: begin
          mem_we  <= 1'b1;
          r_state <= S_WSTROBE;
        end
        S_WSTROBE: begin
          mem_we <= 1'b0;
          if (r_idx == r_nm1) begin
            r_state    <= S_DONE;
            resp_valid <= 1'b1;
          end else begin
            r_idx      <= r_idx + 3'd1;
            mem_waddr  <= mem_waddr + MADDR_SZ'(1);
            mem_datain <= r_wsh[DATA_W-1 -: 8];
            r_wsh      <= r_wsh << 8;
            r_state    <= S_WSETUP;
          end
        end
        S_DONE: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          req_ready  <= 1'b1;
          r_state    <= S_IDLE;
        end
        default: begin
          r_state   <= S_IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
